dfd_tnif_sink: RTL
==================

DFD_TNIF_SINK -- requirements
Module: dfd_tnif_sink

Interface
REQ-001 SHALL have parameter DATA_WIDTH_IN_BYTES, default TNIF_DATA_OUT_WIDTH_IN_BYTES, trace data width in bytes (W = DATA_WIDTH_IN_BYTES*8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries per source FIFO; power of two, >= 2.
REQ-003 SHALL have ports, all in dfd_tn_pkg scope, one clock; reset is asynchronous and active-low:
- clock  input  1  sole clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- enable_in  input  1  sink enable; gates grant
- tr_valid_in  input  1  packet valid from trace network
- tr_src_in  input  1  packet source: 0 = DST, 1 = NTR
- tr_data_in  input  W  packet data
- tr_gnt_out  output  1  grant to trace network
- dst_bp_out / ntr_bp_out  output  1 each  per-source backpressure
- dst_flush_req_in / ntr_flush_req_in  input  1 each  flush request from sink control
- dst_flush_out / ntr_flush_out  output  1 each  flush to trace network
- dst_valid_out / ntr_valid_out  output  1 each  FIFO head valid to consumer
- dst_data_out / ntr_data_out  output  W each  FIFO head data
- dst_ready_in / ntr_ready_in  input  1 each  consumer accepts head
- dst_drop_cnt_out / ntr_drop_cnt_out  output  8 each  saturating dropped-packet count
- proto_err_out  output  1  sticky protocol error

Function
REQ-004 SHALL register enable_in into tr_gnt_out (1-cycle latency).
REQ-005 SHALL register dst_flush_req_in/ntr_flush_req_in into dst_flush_out/ntr_flush_out (1-cycle latency).
REQ-006 SHALL keep one FIFO per source, FIFO_DEPTH entries, with count of width clog2(FIFO_DEPTH)+1 and wrapping read/write pointers.
REQ-007 SHALL steer packet (tr_valid_in=1) to DST FIFO when tr_src_in=0, NTR FIFO when tr_src_in=1.
REQ-008 SHALL drive x_bp_out = 1 exactly when registered x count == FIFO_DEPTH, combinationally from the count.
REQ-009 SHALL write packet into its FIFO when count < FIFO_DEPTH, or count == FIFO_DEPTH with same-cycle pop of that FIFO.
REQ-010 SHALL otherwise drop the packet: increment x drop count, saturating at 255.
REQ-011 SHALL set proto_err_out on a drop while x_flush_out = 0 (backpressure violation).
REQ-012 SHALL NOT set proto_err_out on a drop while x_flush_out = 1 (source ignores bp during flush by protocol).
REQ-013 SHALL set proto_err_out on tr_valid_in = 1 with tr_gnt_out = 0; the packet is still written/dropped per REQ-009/010.
REQ-014 SHALL hold proto_err_out sticky until reset.
REQ-015 SHALL drive x_valid_out = (count != 0) and x_data_out = head entry; pop on x_valid_out & x_ready_in.
REQ-016 SHALL make written data visible at head no earlier than the cycle after the write (no bypass).
REQ-017 SHALL update count on simultaneous push+pop: unchanged; push only: +1; pop only: -1.
REQ-018 SHALL hold x_data_out stable while x_valid_out=1 and x_ready_in=0.
REQ-019 SHALL operate DST and NTR paths fully independently; only one packet arrives per cycle.

Reset
REQ-020 SHALL, while reset_n=0, drive tr_gnt_out=0, flush outs=0, bp outs=0, valid outs=0, drop counts=0, proto_err_out=0, and empty both FIFOs and pointers.
REQ-021 SHALL, on reset assertion mid-operation, discard all FIFO contents immediately (asynchronously) and restart from REQ-020 values.
REQ-022 SHALL not require data-storage reset; data outputs are don't-care while valid=0.

Verification
REQ-023 SHALL cover fill-and-drain: DEPTH=4, enable=1, 4 DST packets 0xA0..0xA3, dst_ready=0 -> dst_bp_out=1 after 4th write, ntr_bp_out=0; then ready=1 -> outputs 0xA0..0xA3 in order, bp drops when count=3.
REQ-024 SHALL cover interleaved sources: alternating src 0/1 each cycle, both readies=1 -> each FIFO delivers its own packets in order, no drops, proto_err_out=0.
REQ-025 SHALL cover flush overflow: DST FIFO full, dst_flush_req_in=1, 3 more DST packets, no pop -> dst_drop_cnt_out=3, proto_err_out=0, FIFO contents unchanged.
REQ-026 SHALL cover bp violation and push-at-full: DST full, no flush, 1 packet with no pop -> drop count 1, proto_err_out=1; 1 packet with dst_ready=1 -> accepted, count stays 4.
REQ-027 SHALL cover grant violation and saturation: enable_in=0, one packet -> proto_err_out=1; 300 flush drops -> drop count 255.
REQ-028 SHALL cover reset mid-stream: reset_n low with 2 entries queued -> all outputs to reset values same cycle; after release, FIFOs empty, gnt=1 one cycle after enable.

Source files
------------

// File: rtl/dfd_tnif_sink_if.sv
// Trace-network sink shared width package and the bundled trace/consumer signal interface.
// The master modport is the network+consumer side; the slave modport is the sink itself.
package dfd_tn_pkg;
  localparam int TNIF_DATA_OUT_WIDTH_IN_BYTES = 4;
endpackage

interface dfd_tnif_sink_if #(
  parameter int DATA_WIDTH_IN_BYTES = dfd_tn_pkg::TNIF_DATA_OUT_WIDTH_IN_BYTES
);
  localparam int W = DATA_WIDTH_IN_BYTES * 8;

  logic         tr_valid_in;
  logic         tr_src_in;
  logic [W-1:0] tr_data_in;
  logic         tr_gnt_out;
  logic         dst_bp_out;
  logic         ntr_bp_out;
  logic         dst_flush_req_in;
  logic         ntr_flush_req_in;
  logic         dst_flush_out;
  logic         ntr_flush_out;
  logic         dst_valid_out;
  logic         ntr_valid_out;
  logic [W-1:0] dst_data_out;
  logic [W-1:0] ntr_data_out;
  logic         dst_ready_in;
  logic         ntr_ready_in;
  logic [7:0]   dst_drop_cnt_out;
  logic [7:0]   ntr_drop_cnt_out;
  logic         proto_err_out;

  modport master (
    output tr_valid_in, tr_src_in, tr_data_in,
    output dst_flush_req_in, ntr_flush_req_in, dst_ready_in, ntr_ready_in,
    input  tr_gnt_out, dst_bp_out, ntr_bp_out, dst_flush_out, ntr_flush_out,
    input  dst_valid_out, ntr_valid_out, dst_data_out, ntr_data_out,
    input  dst_drop_cnt_out, ntr_drop_cnt_out, proto_err_out
  );

  modport slave (
    input  tr_valid_in, tr_src_in, tr_data_in,
    input  dst_flush_req_in, ntr_flush_req_in, dst_ready_in, ntr_ready_in,
    output tr_gnt_out, dst_bp_out, ntr_bp_out, dst_flush_out, ntr_flush_out,
    output dst_valid_out, ntr_valid_out, dst_data_out, ntr_data_out,
    output dst_drop_cnt_out, ntr_drop_cnt_out, proto_err_out
  );
endinterface

// File: rtl/dfd_tnif_sink.sv
// Trace-network sink: steers incoming packets into per-source FIFOs (DST=0, NTR=1),
// counts drops on overflow and flags backpressure/grant protocol violations.
module dfd_tnif_sink
  import dfd_tn_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = TNIF_DATA_OUT_WIDTH_IN_BYTES,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           enable_in,
  dfd_tnif_sink_if.slave bus
);
  localparam int W  = DATA_WIDTH_IN_BYTES * 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic         gnt_q;
  logic         err_q, err_d;
  logic         flush_q   [2];
  logic         flush_req [2];
  logic         ready     [2];
  logic         push_req  [2];
  logic         pop       [2];
  logic         wr_en     [2];
  logic         drop      [2];
  logic         valid     [2];
  logic         full      [2];
  logic [W-1:0] head      [2];
  logic [7:0]   drop_cnt  [2];

  assign flush_req[0] = bus.dst_flush_req_in;
  assign flush_req[1] = bus.ntr_flush_req_in;
  assign ready[0]     = bus.dst_ready_in;
  assign ready[1]     = bus.ntr_ready_in;

  for (genvar s = 0; s < 2; s++) begin : g_src
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic [W-1:0]  mem_q [FIFO_DEPTH];

    assign push_req[s] = bus.tr_valid_in && ((s == 1) ? bus.tr_src_in : !bus.tr_src_in);
    assign valid[s]    = (cnt_q != '0);
    assign full[s]     = (cnt_q == DEPTH_C);
    assign pop[s]      = valid[s] && ready[s];
    // A full FIFO can still take a packet when its head leaves in the same cycle.
    assign wr_en[s]    = push_req[s] && (!full[s] || pop[s]);
    assign drop[s]     = push_req[s] && !wr_en[s];
    assign head[s]     = mem_q[rd_ptr_q];
    assign drop_cnt[s] = drop_cnt_q;

    always_comb begin
      cnt_d      = cnt_q;
      drop_cnt_d = drop_cnt_q;
      case ({wr_en[s], pop[s]})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      if (drop[s] && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q      <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        drop_cnt_q <= '0;
      end else begin
        cnt_q      <= cnt_d;
        drop_cnt_q <= drop_cnt_d;
        if (wr_en[s]) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop[s])   rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end

    // Storage carries no reset; the head is only meaningful while valid is high.
    always_ff @(posedge clock) begin
      if (wr_en[s]) mem_q[wr_ptr_q] <= bus.tr_data_in;
    end
  end

  always_comb begin
    err_d = err_q;
    if ((drop[0] && !flush_q[0]) || (drop[1] && !flush_q[1]) ||
        (bus.tr_valid_in && !gnt_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q      <= 1'b0;
      flush_q[0] <= 1'b0;
      flush_q[1] <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      gnt_q      <= enable_in;
      flush_q[0] <= flush_req[0];
      flush_q[1] <= flush_req[1];
      err_q      <= err_d;
    end
  end

  assign bus.tr_gnt_out       = gnt_q;
  assign bus.dst_flush_out    = flush_q[0];
  assign bus.ntr_flush_out    = flush_q[1];
  assign bus.dst_bp_out       = full[0];
  assign bus.ntr_bp_out       = full[1];
  assign bus.dst_valid_out    = valid[0];
  assign bus.ntr_valid_out    = valid[1];
  assign bus.dst_data_out     = head[0];
  assign bus.ntr_data_out     = head[1];
  assign bus.dst_drop_cnt_out = drop_cnt[0];
  assign bus.ntr_drop_cnt_out = drop_cnt[1];
  assign bus.proto_err_out    = err_q;

endmodule
